// File: rtl/camera_frame_tx.sv
// Camera frame transmitter: streams one vsync/href framed image
// from a valid-qualified pixel source, optionally back to back.
`timescale 1ns/1ps
module camera_frame_tx #(
   parameter int LINE_W     = 16,
   parameter int LINES      = 8,
   parameter int VSYNC_CYC  = 4,
   parameter int HBLANK_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cont,
   input  logic       pix_valid,
   input  logic [7:0] pix_data,
   output logic       pix_ready,
   output logic       vsync,
   output logic       href,
   output logic [7:0] pix_out,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun,
   output logic [7:0] frame_cnt
);

   localparam logic [7:0] C_V_END = 8'(VSYNC_CYC - 1);
   localparam logic [7:0] C_W_END = 8'(LINE_W - 1);
   localparam logic [7:0] C_H_END = 8'(HBLANK_CYC - 1);
   localparam logic [7:0] C_L_END = 8'(LINES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_LINE,
      S_HBLANK,
      S_DONE
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_cyc;
   logic [7:0] w_cyc_nxt;
   logic [7:0] r_line;
   logic [7:0] w_line_nxt;
   logic       w_start_acc;
   logic       w_frame_end;
   logic       w_in_line;
   logic       r_vsync;
   logic       r_href;
   logic [7:0] r_pix_out;
   logic       r_underrun;
   logic [7:0] r_frame_cnt;

   // Next state plus phase/line counters; each phase counts up to its end.
   always_comb begin
      w_state_nxt = r_state;
      w_cyc_nxt   = r_cyc;
      w_line_nxt  = r_line;
      w_start_acc = 1'b0;
      w_frame_end = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_VSYNC;
               w_cyc_nxt   = 8'd0;
               w_line_nxt  = 8'd0;
               w_start_acc = 1'b1;
            end
         end
         S_VSYNC: begin
            if (r_cyc == C_V_END) begin
               w_state_nxt = S_LINE;
               w_cyc_nxt   = 8'd0;
               w_line_nxt  = 8'd0;
            end else begin
               w_cyc_nxt = r_cyc + 8'd1;
            end
         end
         S_LINE: begin
            if (r_cyc == C_W_END) begin
               w_state_nxt = S_HBLANK;
               w_cyc_nxt   = 8'd0;
            end else begin
               w_cyc_nxt = r_cyc + 8'd1;
            end
         end
         S_HBLANK: begin
            if (r_cyc == C_H_END) begin
               w_cyc_nxt = 8'd0;
               if (r_line == C_L_END) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_LINE;
                  w_line_nxt  = r_line + 8'd1;
               end
            end else begin
               w_cyc_nxt = r_cyc + 8'd1;
            end
         end
         S_DONE: begin
            w_frame_end = 1'b1;
            w_cyc_nxt   = 8'd0;
            w_line_nxt  = 8'd0;
            w_state_nxt = cont ? S_VSYNC : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cyc_nxt   = 8'd0;
            w_line_nxt  = 8'd0;
         end
      endcase
   end

   // State, counters and completed-frame count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cyc       <= 8'd0;
         r_line      <= 8'd0;
         r_frame_cnt <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cyc   <= w_cyc_nxt;
         r_line  <= w_line_nxt;
         if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign w_in_line = (r_state == S_LINE);

   // Receiver-side outputs, one cycle behind the state; starved slots send 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vsync    <= 1'b0;
         r_href     <= 1'b0;
         r_pix_out  <= 8'h00;
         r_underrun <= 1'b0;
      end else begin
         r_vsync   <= (r_state == S_VSYNC);
         r_href    <= w_in_line;
         r_pix_out <= (w_in_line && pix_valid) ? pix_data : 8'h00;
         if (w_start_acc) begin
            r_underrun <= 1'b0;
         end else if (w_in_line && !pix_valid) begin
            r_underrun <= 1'b1;
         end
      end
   end

   assign pix_ready  = w_in_line;
   assign busy       = (r_state != S_IDLE);
   assign frame_done = (r_state == S_DONE);
   assign vsync      = r_vsync;
   assign href       = r_href;
   assign pix_out    = r_pix_out;
   assign underrun   = r_underrun;
   assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_camera_frame_tx.sv
// Bench for camera_frame_tx: frame-position reference model
// plus per-scenario checks of framing, data, underrun and counters.
`timescale 1ns/1ps
module tb_camera_frame_tx;

   localparam int LW = 16;
   localparam int LN = 8;
   localparam int VC = 4;
   localparam int HB = 2;
   localparam int FL = VC + LN * (LW + HB) + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic       pix_valid = 1'b0;
   logic [7:0] pix_data = 8'h00;
   logic       pix_ready;
   logic       vsync;
   logic       href;
   logic [7:0] pix_out;
   logic       busy;
   logic       frame_done;
   logic       underrun;
   logic [7:0] frame_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   camera_frame_tx #(
      .LINE_W(LW), .LINES(LN),
      .VSYNC_CYC(VC), .HBLANK_CYC(HB)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .cont(cont), .pix_valid(pix_valid),
      .pix_data(pix_data), .pix_ready(pix_ready),
      .vsync(vsync), .href(href), .pix_out(pix_out),
      .busy(busy), .frame_done(frame_done),
      .underrun(underrun), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: position within the frame (-1 = idle).
   // 0=idle 1=vsync 2=line 3=hblank 4=done
   function automatic int phase(int p);
      int j;
      if (p < 0) return 0;
      if (p < VC) return 1;
      j = p - VC;
      if (j >= LN * (LW + HB)) return 4;
      return ((j % (LW + HB)) < LW) ? 2 : 3;
   endfunction

   int         m_pos = -1;
   int         m_ph;
   logic       m_vs = 1'b0;
   logic       m_hr = 1'b0;
   logic       m_un = 1'b0;
   logic [7:0] m_px = 8'h00;
   logic [7:0] m_cnt = 8'h00;
   logic [21:0] obs;
   logic [21:0] exp_v;

   always_comb m_ph = phase(m_pos);

   always @(posedge clk) begin
      if (rst) begin
         m_pos <= -1;
         m_vs  <= 1'b0;
         m_hr  <= 1'b0;
         m_un  <= 1'b0;
         m_px  <= 8'h00;
         m_cnt <= 8'h00;
      end else begin
         m_vs <= (m_ph == 1);
         m_hr <= (m_ph == 2);
         m_px <= (m_ph == 2 && pix_valid) ? pix_data : 8'h00;
         if (m_ph == 0 && start) m_un <= 1'b0;
         else if (m_ph == 2 && !pix_valid) m_un <= 1'b1;
         if (m_ph == 0) begin
            m_pos <= start ? 0 : -1;
         end else if (m_pos == FL - 1) begin
            m_cnt <= m_cnt + 8'd1;
            m_pos <= cont ? 0 : -1;
         end else begin
            m_pos <= m_pos + 1;
         end
      end
   end

   assign obs = {pix_ready, vsync, href, pix_out,
                 busy, frame_done, underrun, frame_cnt};
   always_comb exp_v = {m_ph == 2, m_vs, m_hr, m_px,
                        m_pos >= 0, m_ph == 4, m_un, m_cnt};

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; pix_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== 22'h0) begin
            n_bad++;
            $display("FAIL reset_vals got=%h exp=%h", obs, 22'h0);
         end
      end
      rst = 1'b0; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL reset_idle got=%h exp=%h", obs, exp_v);
         end
      end
   endtask

   task automatic test_single_frame();
      int src = 0;
      int bn = 0;
      int done_at = -1;
      int vs_n = 0;
      int both = 0;
      int run = 0;
      int gap = 0;
      logic [7:0] got[$];
      int runs[$];
      int gaps[$];
      @(negedge clk);
      start = 1'b1; pix_valid = 1'b1; pix_data = 8'h00;
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
         end
         start = 1'b0;
         if (busy) bn++;
         if (frame_done && done_at < 0) done_at = bn;
         if (vsync) vs_n++;
         if (vsync && href) both++;
         if (href) begin
            if (run == 0 && runs.size() > 0) gaps.push_back(gap);
            got.push_back(pix_out);
            run++;
            gap = 0;
         end else begin
            if (run > 0) runs.push_back(run);
            run = 0;
            gap++;
         end
         pix_data = 8'(src);
         if (pix_ready) src++;
      end
      n_cmp++;
      if (vs_n != VC) begin
         n_bad++;
         $display("FAIL single_vsync_len got=%0d exp=%0d", vs_n, VC);
      end
      n_cmp++;
      if (both != 0) begin
         n_bad++;
         $display("FAIL single_vs_href got=%0d exp=0", both);
      end
      n_cmp++;
      if (got.size() != LW * LN) begin
         n_bad++;
         $display("FAIL single_npix got=%0d exp=%0d", got.size(), LW * LN);
      end
      for (int i = 0; i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== 8'(i)) begin
            n_bad++;
            $display("FAIL single_pix[%0d] got=%h exp=%h", i, got[i], 8'(i));
         end
      end
      n_cmp++;
      if (runs.size() != LN) begin
         n_bad++;
         $display("FAIL single_runs got=%0d exp=%0d", runs.size(), LN);
      end
      foreach (runs[i]) begin
         n_cmp++;
         if (runs[i] != LW) begin
            n_bad++;
            $display("FAIL single_run[%0d] got=%0d exp=%0d", i, runs[i], LW);
         end
      end
      foreach (gaps[i]) begin
         n_cmp++;
         if (gaps[i] != HB) begin
            n_bad++;
            $display("FAIL single_gap[%0d] got=%0d exp=%0d", i, gaps[i], HB);
         end
      end
      n_cmp++;
      if (done_at != FL || bn != FL) begin
         n_bad++;
         $display("FAIL single_len got=%0d/%0d exp=%0d", done_at, bn, FL);
      end
      n_cmp++;
      if (frame_cnt !== 8'd1 || underrun !== 1'b0) begin
         n_bad++;
         $display("FAIL single_end cnt=%0d un=%b exp=1/0", frame_cnt, underrun);
      end
   endtask

   task automatic test_underrun();
      int idx = 0;
      int hcnt = 0;
      int first_un = -1;
      logic [7:0] sent[$];
      logic [7:0] got[$];
      @(negedge clk);
      start = 1'b1; pix_valid = 1'b1; pix_data = 8'($urandom);
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL under_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
         end
         start = 1'b0;
         if (href) begin
            got.push_back(pix_out);
            hcnt++;
         end
         if (underrun && first_un < 0) first_un = hcnt;
         pix_valid = (idx != 5);
         pix_data = 8'($urandom);
         if (pix_ready) begin
            sent.push_back(pix_valid ? pix_data : 8'h00);
            idx++;
         end
      end
      n_cmp++;
      if (got.size() != sent.size() || got.size() != LW * LN) begin
         n_bad++;
         $display("FAIL under_npix got=%0d exp=%0d", got.size(), sent.size());
      end
      for (int i = 0; i < got.size() && i < sent.size(); i++) begin
         n_cmp++;
         if (got[i] !== sent[i]) begin
            n_bad++;
            $display("FAIL under_pix[%0d] got=%h exp=%h", i, got[i], sent[i]);
         end
      end
      n_cmp++;
      if (got.size() > 5 && got[5] !== 8'h00) begin
         n_bad++;
         $display("FAIL under_slot got=%h exp=00", got[5]);
      end
      n_cmp++;
      if (first_un != 6) begin
         n_bad++;
         $display("FAIL under_rise got=%0d exp=6", first_un);
      end
      pix_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (underrun !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL under_sticky un=%b busy=%b exp=1/0", underrun, busy);
         end
      end
      start = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (underrun !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL under_clear un=%b busy=%b exp=0/1", underrun, busy);
      end
      start = 1'b0;
      for (int i = 0; i < 155; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL under_rand cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
         end
         pix_valid = ($urandom_range(0, 7) != 0);
         pix_data = 8'($urandom);
      end
      pix_valid = 1'b1;
   endtask

   task automatic test_rst_mid();
      int bn = 0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 200 && bn < 66; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL rmid_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
         end
         start = 1'b0;
         if (busy) bn++;
         pix_data = 8'($urandom);
      end
      n_cmp++;
      if (bn != 66 || pix_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rmid_where bn=%0d rdy=%b exp=66/1", bn, pix_ready);
      end
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (obs !== 22'h0) begin
         n_bad++;
         $display("FAIL rmid_reset got=%h exp=%h", obs, 22'h0);
      end
      rst = 1'b0; start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== 22'h0) begin
            n_bad++;
            $display("FAIL rmid_idle got=%h exp=%h", obs, 22'h0);
         end
      end
      start = 1'b1;
      bn = 0;
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL rmid_frame cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
         end
         start = 1'b0;
         if (busy) bn++;
         if (i == 1) begin
            n_cmp++;
            if (vsync !== 1'b1) begin
               n_bad++;
               $display("FAIL rmid_vsync got=%b exp=1", vsync);
            end
         end
         pix_data = 8'($urandom);
      end
      n_cmp++;
      if (bn != FL || frame_cnt !== 8'd1) begin
         n_bad++;
         $display("FAIL rmid_end len=%0d cnt=%0d exp=%0d/1", bn, frame_cnt, FL);
      end
   endtask

   task automatic test_start_in_line();
      int bn = 0;
      int dn = 0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 170; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL sil_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
         end
         start = 1'b0;
         if (busy) bn++;
         if (frame_done) dn++;
         if (bn == 30 && busy) begin
            n_cmp++;
            if (pix_ready !== 1'b1) begin
               n_bad++;
               $display("FAIL sil_in_line got=%b exp=1", pix_ready);
            end
            start = 1'b1;
         end
         pix_data = 8'($urandom);
      end
      n_cmp++;
      if (bn != FL || dn != 1) begin
         n_bad++;
         $display("FAIL sil_len len=%0d done=%0d exp=%0d/1", bn, dn, FL);
      end
   endtask

   task automatic test_cont();
      int dn = 0;
      int drops = 0;
      int dcyc[$];
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; cont = 1'b1; start = 1'b1;
      for (int i = 0; i < 3 * FL + 20; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL cont_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
         end
         start = 1'b0;
         if (dn < 3 && !busy) drops++;
         if (frame_done) begin
            dn++;
            dcyc.push_back(cyc);
            if (dn == 3) cont = 1'b0;
         end
         pix_valid = ($urandom_range(0, 15) != 0);
         pix_data = 8'($urandom);
      end
      cont = 1'b0; pix_valid = 1'b1;
      n_cmp++;
      if (drops != 0 || dn != 3) begin
         n_bad++;
         $display("FAIL cont_busy drops=%0d done=%0d exp=0/3", drops, dn);
      end
      for (int i = 1; i < dcyc.size(); i++) begin
         n_cmp++;
         if (dcyc[i] - dcyc[i-1] != FL) begin
            n_bad++;
            $display("FAIL cont_gap got=%0d exp=%0d", dcyc[i] - dcyc[i-1], FL);
         end
      end
      n_cmp++;
      if (frame_cnt !== 8'd3 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL cont_end cnt=%0d busy=%b exp=3/0", frame_cnt, busy);
      end
   endtask

   task automatic test_back_to_back();
      int dn = 0;
      int rdy = 0;
      int both = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; cont = 1'b1; start = 1'b1;
      for (int i = 0; i < 256 * FL + 20; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
         end
         start = 1'b0;
         if (pix_ready) rdy++;
         if (vsync && href) both++;
         if (frame_done) begin
            dn++;
            n_cmp++;
            if (rdy != LW * LN) begin
               n_bad++;
               $display("FAIL b2b_ready f=%0d got=%0d exp=%0d", dn, rdy, LW * LN);
            end
            rdy = 0;
            if (dn == 256) cont = 1'b0;
         end
         pix_valid = ($urandom_range(0, 31) != 0);
         pix_data = 8'($urandom);
         if (($urandom_range(0, 63) == 0)) start = 1'b1;
      end
      cont = 1'b0; start = 1'b0; pix_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (both != 0 || dn != 256) begin
         n_bad++;
         $display("FAIL b2b_frames both=%0d done=%0d exp=0/256", both, dn);
      end
      n_cmp++;
      if (frame_cnt !== 8'd0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_wrap cnt=%0d busy=%b exp=0/0", frame_cnt, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_underrun();
      test_rst_mid();
      test_start_in_line();
      test_cont();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/camera_frame_tx.md
CAMERA_FRAME_TX -- requirements
Module: camera_frame_tx

Interface
REQ-001 Parameter LINE_W, default 16, pixels per line (1..255).
REQ-002 Parameter LINES, default 8, lines per frame (1..255; LINE_W*LINES SHALL be <= 4095).
REQ-003 Parameter VSYNC_CYC, default 4, vsync pulse length in cycles (1..255).
REQ-004 Parameter HBLANK_CYC, default 2, href-low gap after every line, including the last (1..255).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 start  input  1  request one frame; sampled only in IDLE.
REQ-008 cont  input  1  continuous mode; sampled in DONE.
REQ-009 pix_valid  input  1  source pixel available.
REQ-010 pix_data  input  8  source pixel, RGB332 (R[7:5] G[4:2] B[1:0]).
REQ-011 pix_ready  output  1  block consumes pix_data this cycle.
REQ-012 vsync  output  1  frame sync to the pixel receiver, registered.
REQ-013 href  output  1  line valid to the pixel receiver, registered.
REQ-014 pix_out  output  8  pixel to the receiver, registered.
REQ-015 busy  output  1  FSM not in IDLE.
REQ-016 frame_done  output  1  one-cycle end-of-frame pulse.
REQ-017 underrun  output  1  sticky flag: a pixel slot had no valid source data.
REQ-018 frame_cnt  output  8  completed-frame counter.

Function
REQ-019 FSM states SHALL be IDLE, VSYNC, LINE, HBLANK, DONE.
REQ-020 IDLE -> VSYNC when start=1; start outside IDLE SHALL be ignored.
REQ-021 Accepting start SHALL clear underrun in the same edge.
REQ-022 VSYNC SHALL last exactly VSYNC_CYC cycles, then go to LINE with line counter 0.
REQ-023 LINE SHALL last exactly LINE_W cycles, then go to HBLANK.
REQ-024 HBLANK SHALL last exactly HBLANK_CYC cycles.
REQ-025 At the end of HBLANK, the FSM SHALL go to LINE, or to DONE if the finished line was LINES-1.
REQ-026 DONE SHALL last one cycle.
REQ-027 On leaving DONE, the FSM SHALL go to VSYNC if cont=1 (no start needed), else to IDLE.
REQ-028 Frame length SHALL be VSYNC_CYC + LINES*(LINE_W+HBLANK_CYC) + 1 cycles (149 at defaults).
REQ-029 pix_ready SHALL equal (state==LINE), combinationally; the block never stalls the line for the source.
REQ-030 On an edge where state==LINE: href<=1, and pix_out<=pix_data if pix_valid=1, else pix_out<=8'h00 and underrun<=1.
REQ-031 On an edge where state!=LINE: href<=0, pix_out<=8'h00.
REQ-032 On every edge: vsync<=(state==VSYNC).
REQ-033 vsync/href/pix_out SHALL lag the FSM state by exactly one cycle; a ready&valid transfer in cycle t appears on pix_out in cycle t+1.
REQ-034 vsync and href SHALL never be high in the same cycle.
REQ-035 href SHALL be high for exactly LINE_W*LINES cycles per frame, in LINES runs of LINE_W.
REQ-036 href SHALL be low for at least one cycle after the last pixel with vsync low, so the receiver sees frame end.
REQ-037 frame_done SHALL equal (state==DONE), combinationally.
REQ-038 frame_cnt SHALL increment by 1 on leaving DONE, wrapping 255 -> 0.
REQ-039 busy SHALL equal (state!=IDLE); in continuous mode busy stays high across frame boundaries.
REQ-040 Internal counters SHALL be sized for parameter maxima; no count SHALL exceed its terminal value.

Reset
REQ-041 rst=1 at an edge SHALL force: state=IDLE, all counters=0, vsync=0, href=0, pix_out=8'h00, underrun=0, frame_cnt=0.
REQ-042 After that edge, pix_ready=0, busy=0 and frame_done=0.
REQ-043 rst SHALL take priority over start, including mid-frame; the next frame SHALL start only from a fresh start after rst is released.

Verification
REQ-044 Defaults, pix_valid=1 with an incrementing source, one start pulse -> vsync high 4 cycles; then 8 href runs of 16 separated by 2 low cycles; pix_out=0x00..0x7F in order; frame_done after 149 cycles; frame_cnt=1; underrun=0.
REQ-045 pix_valid held 0 during pixel 5 of line 0 -> that pix_out=0x00, underrun=1 and stays 1 until the next accepted start.
REQ-046 cont=1 for 3 frames -> busy never drops; 3 frame_done pulses exactly 149 cycles apart; frame_cnt=3.
REQ-047 rst asserted in the middle of line 3 -> next cycle all outputs at reset values and FSM in IDLE; start afterwards -> full frame from vsync.
REQ-048 start pulsed during LINE -> no effect on timing; frame_cnt wrap: 256 frames with cont=1 -> frame_cnt=0.
REQ-049 All frames -> checker confirms vsync&href never both high and pix_ready high exactly 128 cycles per frame.
